// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow errors and a synchronous flush.
module fifo_level #(
    parameter int B        = 32,
    parameter int W        = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   level,
    output logic         overflow,
    output logic         underflow
);

    localparam int         D      = 2 ** W;
    localparam logic [W:0] DEPTH  = (W + 1)'(D);
    localparam logic [W:0] AF_THR = (W + 1)'(AF_LEVEL);
    localparam logic [W:0] AE_THR = (W + 1)'(AE_LEVEL);

    logic [B-1:0] r_mem [D];
    logic [W-1:0] r_wptr;
    logic [W-1:0] r_rptr;
    logic [W:0]   r_level;
    logic         r_empty;
    logic         r_full;
    logic         r_almost_empty;
    logic         r_almost_full;
    logic         r_overflow;
    logic         r_underflow;

    logic         w_rd_ok;
    logic         w_wr_ok;
    logic [W:0]   w_level_next;

    // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside it.
    assign w_rd_ok = rd & ~r_empty;
    assign w_wr_ok = wr & (~r_full | w_rd_ok);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_level_next = r_level;
        if (w_wr_ok && !w_rd_ok) begin
            w_level_next = r_level + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; level and pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (!clr && w_wr_ok) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (clr) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Flags follow next-level so they never lag the count by a cycle.
            r_level        <= w_level_next;
            r_empty        <= (w_level_next == '0);
            r_full         <= (w_level_next == DEPTH);
            r_almost_empty <= (w_level_next <= AE_THR);
            r_almost_full  <= (w_level_next >= AF_THR);
            r_overflow     <= r_overflow  | (wr & ~w_wr_ok);
            r_underflow    <= r_underflow | (rd & ~w_rd_ok);
        end
    end

    assign r_data       = r_mem[r_rptr];
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level: a queue-based reference model predicts the state after
// each edge, and a monitor compares the DUT outputs one step after that edge.
module tb_fifo_level;

    localparam int B  = 8;
    localparam int W  = 2;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         clk;
    logic         reset;
    logic         clr;
    logic         rd;
    logic         wr;
    logic [B-1:0] w_data;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic [W:0]   level;
    logic         overflow;
    logic         underflow;

    fifo_level #(.B(B), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .rd          (rd),
        .wr          (wr),
        .w_data      (w_data),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        int         lvl;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       unf;
        logic [7:0] head;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model_q [$];
    logic       m_ovf;
    logic       m_unf;
    int         n_tests;
    int         n_fail;
    exp_t       mon_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " level"}, 32'(level), 0);
        check({tag, " empty"}, 32'(empty), 1);
        check({tag, " full"}, 32'(full), 0);
        check({tag, " almost_empty"}, 32'(almost_empty), 1);
        check({tag, " almost_full"}, 32'(almost_full), 0);
        check({tag, " overflow"}, 32'(overflow), 0);
        check({tag, " underflow"}, 32'(underflow), 0);
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.lvl  = model_q.size();
        e.emp  = (e.lvl == 0);
        e.ful  = (e.lvl == D);
        e.ae   = (e.lvl <= AE);
        e.af   = (e.lvl >= AF);
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        e.head = (e.lvl > 0) ? model_q[0] : 8'h00;
        return e;
    endfunction

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus: drive away from the rising edge, then predict the post-edge state.
    task automatic step(input logic c, input logic r, input logic w, input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        clr    = c;
        rd     = r;
        wr     = w;
        w_data = d;
        if (c) begin
            model_reset();
        end else begin
            rd_ok = r && (model_q.size() > 0);
            wr_ok = w && ((model_q.size() < D) || rd_ok);
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
        end
        exp_q.push_back(model_snapshot());
    endtask

    task automatic idle();
        @(negedge clk);
        clr = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("level", 32'(level), 32'(mon_e.lvl));
            check("empty", 32'(empty), 32'(mon_e.emp));
            check("full", 32'(full), 32'(mon_e.ful));
            check("almost_empty", 32'(almost_empty), 32'(mon_e.ae));
            check("almost_full", 32'(almost_full), 32'(mon_e.af));
            check("overflow", 32'(overflow), 32'(mon_e.ovf));
            check("underflow", 32'(underflow), 32'(mon_e.unf));
            if (!mon_e.emp) check("r_data", 32'(r_data), 32'(mon_e.head));
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clr     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        w_data  = '0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill to full, watching the threshold flags rise and the head stay put.
        step(0, 0, 1, 8'h11);
        step(0, 0, 1, 8'h22);
        step(0, 0, 1, 8'h33);
        step(0, 0, 1, 8'h44);

        // Dropped write, drain, then a read from empty.
        step(0, 0, 1, 8'h55);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);

        // Simultaneous read/write on an empty FIFO.
        step(0, 1, 1, 8'hA5);

        // Fill, then six simultaneous read/writes at full across the pointer wrap.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h50 + i));
        for (int i = 0; i < 6; i++) step(0, 1, 1, 8'(8'h60 + i));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

        // Flush with a concurrent write while holding three words and overflow set.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h70 + i));
        step(0, 1, 0, 8'h00);
        step(1, 0, 1, 8'hEE);
        step(0, 0, 0, 8'h00);

        // Asynchronous reset between edges while holding two words.
        step(0, 0, 1, 8'h81);
        step(0, 0, 1, 8'h82);
        idle();
        #1 reset = 1'b1;
        #1 check_reset_state("async reset");
        #1 reset = 1'b0;
        model_reset();
        step(0, 0, 1, 8'h91);

        // Randomised traffic: a write-heavy phase then a read-heavy phase to hit both boundaries.
        for (int i = 0; i < 400; i++) begin
            logic c;
            logic r;
            logic w;
            c = ($urandom_range(0, 31) == 0);
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(c, r, w, 8'($urandom));
        end
        idle();
        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
